// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the reorder buffer and its pointer registers.
// Tag 0 means "no producer" and is never allocated.
package reorder_buffer_pkg;

   localparam int ROB_WIDTH  = 4;
   localparam int ROB_SIZE   = 16;
   localparam int REG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   localparam logic [ROB_WIDTH-1:0] ZERO_ROB      = '0;
   localparam logic [ROB_WIDTH-1:0] ROB_FIRST_TAG = ROB_WIDTH'(1);
   localparam logic [ROB_WIDTH-1:0] ROB_LAST_TAG  = ROB_WIDTH'(ROB_SIZE - 1);
   localparam logic [ROB_WIDTH-1:0] ROB_MAX_COUNT = ROB_WIDTH'(ROB_SIZE - 1);
   localparam logic [REG_WIDTH-1:0] ZERO_REG      = '0;

   typedef enum logic {
      ST_RUN,
      ST_FLUSH
   } rob_state_t;

   // Pointer increment that skips tag 0: 1 -> 2 -> ... -> 15 -> 1.
   function automatic logic [ROB_WIDTH-1:0] next_rob(input logic [ROB_WIDTH-1:0] p);
      return (p == ROB_LAST_TAG) ? ROB_FIRST_TAG : p + ROB_WIDTH'(1);
   endfunction

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Circular ROB pointer register, wrapping 15 -> 1 and reloading 1 on flush.
module reorder_buffer_ptr
   import reorder_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 advance,
   input  logic                 restart,
   output logic [ROB_WIDTH-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= ROB_FIRST_TAG;
      end else if (ena) begin
         if (restart) begin
            ptr <= ROB_FIRST_TAG;
         end else if (advance) begin
            ptr <= next_rob(ptr);
         end
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags, collects CDB results, commits the head
// to the register file and turns a mispredicted commit into a one-cycle rollback.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  in_issue_ena,
   input  logic [REG_WIDTH-1:0]  in_issue_rd,
   input  logic                  in_issue_is_store,
   output logic                  out_full,
   output logic [ROB_WIDTH-1:0]  out_next_tag,
   input  logic                  in_alu_ena,
   input  logic [ROB_WIDTH-1:0]  in_alu_tag,
   input  logic [DATA_WIDTH-1:0] in_alu_value,
   input  logic                  in_alu_mispredict,
   input  logic [ADDR_WIDTH-1:0] in_alu_target,
   input  logic                  in_lsb_ena,
   input  logic [ROB_WIDTH-1:0]  in_lsb_tag,
   input  logic [DATA_WIDTH-1:0] in_lsb_value,
   input  logic [ROB_WIDTH-1:0]  in_query_tag1,
   input  logic [ROB_WIDTH-1:0]  in_query_tag2,
   output logic                  out_query_ready1,
   output logic                  out_query_ready2,
   output logic [DATA_WIDTH-1:0] out_query_value1,
   output logic [DATA_WIDTH-1:0] out_query_value2,
   output logic [REG_WIDTH-1:0]  out_commit_reg,
   output logic [ROB_WIDTH-1:0]  out_commit_tag,
   output logic [DATA_WIDTH-1:0] out_commit_value,
   output logic                  out_store_commit,
   output logic                  out_rollback,
   output logic [ADDR_WIDTH-1:0] out_rollback_pc
);

   logic                  busy       [ROB_SIZE];
   logic                  ready      [ROB_SIZE];
   logic [REG_WIDTH-1:0]  rd         [ROB_SIZE];
   logic [DATA_WIDTH-1:0] value      [ROB_SIZE];
   logic                  is_store   [ROB_SIZE];
   logic                  mispredict [ROB_SIZE];
   logic [ADDR_WIDTH-1:0] target     [ROB_SIZE];

   rob_state_t            state;
   logic [ROB_WIDTH-1:0]  head;
   logic [ROB_WIDTH-1:0]  tail;
   logic [ROB_WIDTH-1:0]  count;
   logic [ROB_WIDTH-1:0]  count_next;
   logic [ADDR_WIDTH-1:0] flush_pc;
   logic                  flush_pending;
   logic                  alu_hit;
   logic                  lsb_hit;
   logic                  do_issue;
   logic                  do_commit;
   logic                  head_mis;
   logic [ADDR_WIDTH-1:0] head_target;

   logic [ROB_WIDTH-1:0]  look_tag   [3];
   logic                  look_ready [3];
   logic [DATA_WIDTH-1:0] look_value [3];

   assign flush_pending = (state == ST_FLUSH);
   assign out_full      = (count == ROB_MAX_COUNT);
   assign out_next_tag  = tail;

   assign alu_hit  = in_alu_ena && (in_alu_tag != ZERO_ROB) && busy[in_alu_tag] && !flush_pending;
   assign lsb_hit  = in_lsb_ena && (in_lsb_tag != ZERO_ROB) && busy[in_lsb_tag] && !flush_pending;
   assign do_issue = ena && in_issue_ena && !out_full && !flush_pending;

   // Operand queries and the head share one lookup so the head can retire on a same-cycle CDB hit.
   assign look_tag[0] = in_query_tag1;
   assign look_tag[1] = in_query_tag2;
   assign look_tag[2] = head;

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         look_ready[i] = 1'b0;
         look_value[i] = '0;
         if (look_tag[i] != ZERO_ROB) begin
            if (alu_hit && (in_alu_tag == look_tag[i])) begin
               look_ready[i] = 1'b1;
               look_value[i] = in_alu_value;
            end else if (lsb_hit && (in_lsb_tag == look_tag[i])) begin
               look_ready[i] = 1'b1;
               look_value[i] = in_lsb_value;
            end else begin
               look_ready[i] = ready[look_tag[i]];
               look_value[i] = value[look_tag[i]];
            end
         end
      end
   end

   assign out_query_ready1 = look_ready[0];
   assign out_query_value1 = look_value[0];
   assign out_query_ready2 = look_ready[1];
   assign out_query_value2 = look_value[1];

   always_comb begin
      head_mis    = mispredict[head];
      head_target = target[head];
      if (alu_hit && (in_alu_tag == head)) begin
         head_mis    = in_alu_mispredict;
         head_target = in_alu_target;
      end
   end

   assign do_commit = ena && !flush_pending && busy[head] && look_ready[2];

   always_comb begin
      count_next = count;
      if (do_issue && !do_commit) begin
         count_next = count + ROB_WIDTH'(1);
      end else if (!do_issue && do_commit) begin
         count_next = count - ROB_WIDTH'(1);
      end
   end

   reorder_buffer_ptr u_head (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .advance (do_commit),
      .restart (flush_pending),
      .ptr     (head)
   );

   reorder_buffer_ptr u_tail (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .advance (do_issue),
      .restart (flush_pending),
      .ptr     (tail)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            busy[i]       <= 1'b0;
            ready[i]      <= 1'b0;
            rd[i]         <= '0;
            value[i]      <= '0;
            is_store[i]   <= 1'b0;
            mispredict[i] <= 1'b0;
            target[i]     <= '0;
         end
         state            <= ST_RUN;
         count            <= '0;
         flush_pc         <= '0;
         out_commit_reg   <= ZERO_REG;
         out_commit_tag   <= ZERO_ROB;
         out_commit_value <= '0;
         out_store_commit <= 1'b0;
         out_rollback     <= 1'b0;
         out_rollback_pc  <= '0;
      end else if (ena) begin
         out_commit_reg   <= ZERO_REG;
         out_commit_tag   <= ZERO_ROB;
         out_commit_value <= '0;
         out_store_commit <= 1'b0;
         out_rollback     <= 1'b0;
         if (state == ST_FLUSH) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
               busy[i]       <= 1'b0;
               ready[i]      <= 1'b0;
               mispredict[i] <= 1'b0;
            end
            count           <= '0;
            out_rollback    <= 1'b1;
            out_rollback_pc <= flush_pc;
            state           <= ST_RUN;
         end else begin
            if (do_issue) begin
               busy[tail]       <= 1'b1;
               ready[tail]      <= 1'b0;
               rd[tail]         <= in_issue_rd;
               is_store[tail]   <= in_issue_is_store;
               mispredict[tail] <= 1'b0;
            end
            if (alu_hit) begin
               ready[in_alu_tag]      <= 1'b1;
               value[in_alu_tag]      <= in_alu_value;
               mispredict[in_alu_tag] <= in_alu_mispredict;
               target[in_alu_tag]     <= in_alu_target;
            end
            if (lsb_hit) begin
               ready[in_lsb_tag] <= 1'b1;
               value[in_lsb_tag] <= in_lsb_value;
            end
            // Retirement clears the head last so it overrides a writeback landing on it.
            if (do_commit) begin
               busy[head]       <= 1'b0;
               ready[head]      <= 1'b0;
               mispredict[head] <= 1'b0;
               out_commit_reg   <= rd[head];
               out_commit_tag   <= head;
               out_commit_value <= look_value[2];
               out_store_commit <= is_store[head];
               if (head_mis) begin
                  state    <= ST_FLUSH;
                  flush_pc <= head_target;
               end
            end
            count <= count_next;
         end
      end
   end

endmodule
